pid_output_router: RTL and testbench
====================================

# pid_output_router

Routes the PID pipeline's tagged output stream (dv, chan, data) to the DAC controller and to per-DDS frequency/phase/amplitude controllers. It is the parametrised successor to the fixed DAC-FIFO/DDS-compare output stage. It adds per-DAC-channel latest-value coalescing, round-robin DAC scheduling, drop/coalesce statistics, and a configurable channel map. It sits between `pid_pipeline` and `dac_controller` / `dds_controller[N_DDS]`.

## Interface
- N_DAC, 8, number of DAC channels; chan 0..N_DAC-1 map to DAC channels
- W_DAC_CHAN, 3, DAC channel index width (clog2 N_DAC)
- W_DAC_DATA, 16, DAC word width
- N_DDS, 4, number of DDS devices
- FREQ_BASE, 8, first frequency channel; DDS i frequency = FREQ_BASE+i
- PHASE_BASE, 12, first phase channel
- AMP_BASE, 16, first amplitude channel
- W_CHAN, 5, width of chan_in
- W_DATA, 48, width of data_in
- W_FREQ / W_PHASE / W_AMP, 48 / 14 / 10, DDS word widths
- W_CNT, 16, statistics counter width
- Ranges [0,N_DAC), [FREQ_BASE,+N_DDS), [PHASE_BASE,+N_DDS), [AMP_BASE,+N_DDS) must not overlap
- clk_in  in  1  system clock; the block has one clock
- rst_in  in  1  synchronous, active-high reset
- dv_in  in  1  input word valid, one-cycle pulse
- chan_in  in  W_CHAN  destination channel
- data_in  in  W_DATA  output value; already saturated upstream
- dac_dv_out  out  1  one-cycle pulse: issue write
- dac_chan_out  out  W_DAC_CHAN  channel of issued write
- dac_data_out  out  W_DAC_DATA  data of issued write
- dac_done_in  in  1  DAC controller finished current write (pulse)
- dds_freq_dv_out / dds_phase_dv_out / dds_amp_dv_out  out  N_DDS each  per-DDS update pulses
- dds_freq_out / dds_phase_out / dds_amp_out  out  W_FREQ / W_PHASE / W_AMP  shared registered data buses
- clear_cnt_in  in  1  clear statistics
- coalesce_cnt_out  out  W_CNT  count of overwritten pending DAC values
- drop_cnt_out  out  W_CNT  count of unmapped channels

## Operation
- Decode on dv_in. The destination DAC, freq, phase or amp receives data_in[W_x-1:0] (low-bit slice). Any other chan increments drop_cnt; the word is discarded.
- DAC storage: per channel pend_valid[c] and pend_data[c].
  - On write, data is stored and pend_valid is set.
  - If pend_valid[c] was already set and c is not being issued this cycle, coalesce_cnt increments. The newest value wins.
- DAC scheduler FSM:
  - IDLE: if any pend_valid, select the first set channel searching from rr_ptr+1 with wrap modulo N_DAC. Latch chan/data into outputs, clear its pend_valid, set rr_ptr to it, go to ISSUE.
  - ISSUE: dac_dv_out=1 for exactly one cycle, then go to WAIT.
  - WAIT: hold outputs until dac_done_in, then go to IDLE.
  - dac_done_in outside WAIT is ignored.
- Write to the channel being latched in the same IDLE cycle: the issue uses the old value. pend_valid stays set with the new value. Not counted as coalesce.
- DDS path: on a matching dv_in, the data bus is registered and the matching dv bit pulses for one cycle. Exactly one of the 3×N_DDS bits is high per input word. Buses hold their last value otherwise.
- Counters saturate at all-ones. clear_cnt_in zeroes both. If clear and increment occur in the same cycle, clear wins.

## Timing
- Reset values:
  - All outputs 0.
  - pend_valid all 0, FSM=IDLE, rr_ptr=N_DAC-1 (channel 0 has first priority), counters 0.
- Reset mid-WAIT: returns to IDLE. Pending data is discarded. A late dac_done_in is ignored.
- DDS latency: dv_in at cycle t gives the dv pulse and data at t+1.
- DAC latency with scheduler idle and nothing else pending: dv_in at t sets pend_valid at t+1. IDLE selects at t+1. dac_dv_out is high at t+2.
- Minimum DAC issue spacing: done at cycle d, IDLE at d+1, dac_dv_out at d+2.
- Input accepts one word every cycle; no backpressure. DAC overload is absorbed by coalescing, never by stalling.
- All outputs are registered.

## Test plan
- Reset, then dv_in chan=3 data=0x1234 → dac_dv_out pulses 2 cycles later with chan=3, data=0x1234. Hold in WAIT until dac_done_in.
- While in WAIT, write chan 5 = 0x0001, then chan 5 = 0x0002 → one issue of 0x0002 after done; coalesce_cnt=1.
- Pending on chans 7, 0, 2 with rr_ptr=0 → issue order is 2, 7, 0.
- dv_in chan=FREQ_BASE+1 data=0xABCDEF → next cycle dds_freq_dv_out=4'b0010, dds_freq_out=0xABCDEF. chan=AMP_BASE+3 data=0x7FF → dds_amp_out=0x3FF (slice).
- chan=31 and chan=N_DAC+0 (gap below FREQ_BASE when N_DAC<8) → no outputs; drop_cnt increments per word. Force 2^W_CNT drops → holds 0xFFFF. clear_cnt_in coincident with a drop → 0.
- Assert rst_in in WAIT with two channels pending → outputs 0, nothing issued afterwards. A done pulse on the next cycle causes no issue.

Source files
------------

// File: rtl/pid_output_router.sv
// Output stage of the PID pipeline: decodes tagged words into DAC writes (coalesced,
// round-robin scheduled) and DDS freq/phase/amp update pulses, with drop/coalesce stats.
module pid_output_router #(
    parameter int N_DAC      = 8,
    parameter int W_DAC_CHAN = 3,
    parameter int W_DAC_DATA = 16,
    parameter int N_DDS      = 4,
    parameter int FREQ_BASE  = 8,
    parameter int PHASE_BASE = 12,
    parameter int AMP_BASE   = 16,
    parameter int W_CHAN     = 5,
    parameter int W_DATA     = 48,
    parameter int W_FREQ     = 48,
    parameter int W_PHASE    = 14,
    parameter int W_AMP      = 10,
    parameter int W_CNT      = 16
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  dv_in,
    input  logic [W_CHAN-1:0]     chan_in,
    input  logic [W_DATA-1:0]     data_in,
    output logic                  dac_dv_out,
    output logic [W_DAC_CHAN-1:0] dac_chan_out,
    output logic [W_DAC_DATA-1:0] dac_data_out,
    input  logic                  dac_done_in,
    output logic [N_DDS-1:0]      dds_freq_dv_out,
    output logic [N_DDS-1:0]      dds_phase_dv_out,
    output logic [N_DDS-1:0]      dds_amp_dv_out,
    output logic [W_FREQ-1:0]     dds_freq_out,
    output logic [W_PHASE-1:0]    dds_phase_out,
    output logic [W_AMP-1:0]      dds_amp_out,
    input  logic                  clear_cnt_in,
    output logic [W_CNT-1:0]      coalesce_cnt_out,
    output logic [W_CNT-1:0]      drop_cnt_out
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic [1:0]            state;
    logic [N_DAC-1:0]      pend_valid;
    logic [W_DAC_DATA-1:0] pend_data [N_DAC];
    logic [W_DAC_CHAN-1:0] rr_ptr;

    int                    chan_i;
    logic                  dac_hit;
    logic [W_DAC_CHAN-1:0] dac_idx;
    logic [N_DDS-1:0]      freq_hit, phase_hit, amp_hit;
    logic                  drop;
    logic                  sel_found;
    logic [W_DAC_CHAN-1:0] sel_idx;
    logic [W_DAC_CHAN-1:0] cand;
    logic                  issue_now;
    logic                  coalesce;

    assign chan_i = int'(chan_in);

    always_comb begin
        dac_hit   = dv_in && (chan_i < N_DAC);
        dac_idx   = W_DAC_CHAN'(chan_in);
        freq_hit  = '0;
        phase_hit = '0;
        amp_hit   = '0;
        for (int i = 0; i < N_DDS; i++) begin
            freq_hit[i]  = dv_in && (chan_i == FREQ_BASE + i);
            phase_hit[i] = dv_in && (chan_i == PHASE_BASE + i);
            amp_hit[i]   = dv_in && (chan_i == AMP_BASE + i);
        end
        drop = dv_in && !dac_hit && (freq_hit == '0) && (phase_hit == '0) && (amp_hit == '0);
    end

    // Round-robin: first pending channel strictly after rr_ptr, wrapping.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int i = 1; i <= N_DAC; i++) begin
            cand = W_DAC_CHAN'((int'(rr_ptr) + i) % N_DAC);
            if (!sel_found && pend_valid[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    assign issue_now = (state == S_IDLE) && sel_found;
    assign coalesce  = dac_hit && pend_valid[dac_idx] && !(issue_now && (sel_idx == dac_idx));

    // A write landing on the channel being issued re-arms it after the clear.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pend_valid <= '0;
        end else begin
            if (issue_now) pend_valid[sel_idx] <= 1'b0;
            if (dac_hit)   pend_valid[dac_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (dac_hit) pend_data[dac_idx] <= data_in[W_DAC_DATA-1:0];
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state        <= S_IDLE;
            rr_ptr       <= W_DAC_CHAN'(N_DAC - 1);
            dac_dv_out   <= 1'b0;
            dac_chan_out <= '0;
            dac_data_out <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (sel_found) begin
                        dac_chan_out <= sel_idx;
                        dac_data_out <= pend_data[sel_idx];
                        rr_ptr       <= sel_idx;
                        dac_dv_out   <= 1'b1;
                        state        <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    dac_dv_out <= 1'b0;
                    state      <= S_WAIT;
                end
                S_WAIT: begin
                    if (dac_done_in) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            dds_freq_dv_out  <= '0;
            dds_phase_dv_out <= '0;
            dds_amp_dv_out   <= '0;
            dds_freq_out     <= '0;
            dds_phase_out    <= '0;
            dds_amp_out      <= '0;
        end else begin
            dds_freq_dv_out  <= freq_hit;
            dds_phase_dv_out <= phase_hit;
            dds_amp_dv_out   <= amp_hit;
            if (|freq_hit)  dds_freq_out  <= data_in[W_FREQ-1:0];
            if (|phase_hit) dds_phase_out <= data_in[W_PHASE-1:0];
            if (|amp_hit)   dds_amp_out   <= data_in[W_AMP-1:0];
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in || clear_cnt_in) begin
            coalesce_cnt_out <= '0;
            drop_cnt_out     <= '0;
        end else begin
            if (coalesce && !(&coalesce_cnt_out)) coalesce_cnt_out <= coalesce_cnt_out + W_CNT'(1);
            if (drop && !(&drop_cnt_out))         drop_cnt_out     <= drop_cnt_out + W_CNT'(1);
        end
    end
endmodule

// File: tb/tb_pid_output_router.sv
// Scoreboard bench for pid_output_router: stimulus pushes expected DAC/DDS events,
// a negedge monitor pops and compares whenever the DUT pulses an output.
module tb_pid_output_router;
    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        dv_in;
    logic [4:0]  chan_in;
    logic [47:0] data_in;
    logic        dac_dv_out;
    logic [2:0]  dac_chan_out;
    logic [15:0] dac_data_out;
    logic        dac_done_in;
    logic [3:0]  dds_freq_dv_out, dds_phase_dv_out, dds_amp_dv_out;
    logic [47:0] dds_freq_out;
    logic [13:0] dds_phase_out;
    logic [9:0]  dds_amp_out;
    logic        clear_cnt_in;
    logic [15:0] coalesce_cnt_out, drop_cnt_out;

    pid_output_router dut (
        .clk_in(clk_in), .rst_in(rst_in), .dv_in(dv_in), .chan_in(chan_in), .data_in(data_in),
        .dac_dv_out(dac_dv_out), .dac_chan_out(dac_chan_out), .dac_data_out(dac_data_out),
        .dac_done_in(dac_done_in),
        .dds_freq_dv_out(dds_freq_dv_out), .dds_phase_dv_out(dds_phase_dv_out),
        .dds_amp_dv_out(dds_amp_dv_out), .dds_freq_out(dds_freq_out),
        .dds_phase_out(dds_phase_out), .dds_amp_out(dds_amp_out),
        .clear_cnt_in(clear_cnt_in), .coalesce_cnt_out(coalesce_cnt_out),
        .drop_cnt_out(drop_cnt_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct { logic [2:0] ch; logic [15:0] d; } dac_exp_t;
    typedef struct { int kind; logic [3:0] bits; logic [47:0] d; } dds_exp_t;
    dac_exp_t dac_q[$];
    dds_exp_t dds_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    logic prev_dac_dv = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_dac(input logic [2:0] ch, input logic [15:0] d);
        dac_exp_t e;
        e.ch = ch; e.d = d;
        dac_q.push_back(e);
    endtask

    task automatic push_dds(input int kind, input logic [3:0] bits, input logic [47:0] d);
        dds_exp_t e;
        e.kind = kind; e.bits = bits; e.d = d;
        dds_q.push_back(e);
    endtask

    // Monitor
    always @(negedge clk_in) begin
        dac_exp_t de;
        dds_exp_t xe;
        if (dac_dv_out) begin
            if (dac_q.size() == 0) begin
                chk("dac_unexpected_issue", {45'd0, dac_chan_out, dac_data_out}, 64'h0);
            end else begin
                de = dac_q.pop_front();
                chk("dac_chan", 64'(dac_chan_out), 64'(de.ch));
                chk("dac_data", 64'(dac_data_out), 64'(de.d));
            end
            if (prev_dac_dv) chk("dac_pulse_width", 64'd2, 64'd1);
        end
        prev_dac_dv = dac_dv_out;
        if (|{dds_freq_dv_out, dds_phase_dv_out, dds_amp_dv_out}) begin
            if (dds_q.size() == 0) begin
                chk("dds_unexpected_pulse", 64'({dds_freq_dv_out, dds_phase_dv_out, dds_amp_dv_out}), 64'h0);
            end else begin
                xe = dds_q.pop_front();
                chk("dds_dv_bits", 64'({dds_freq_dv_out, dds_phase_dv_out, dds_amp_dv_out}),
                    64'({(xe.kind == 0) ? xe.bits : 4'h0, (xe.kind == 1) ? xe.bits : 4'h0,
                         (xe.kind == 2) ? xe.bits : 4'h0}));
                if (xe.kind == 0)      chk("dds_freq_bus",  64'(dds_freq_out),  64'(xe.d));
                else if (xe.kind == 1) chk("dds_phase_bus", 64'(dds_phase_out), 64'(xe.d));
                else                   chk("dds_amp_bus",   64'(dds_amp_out),   64'(xe.d));
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic send(input int ch, input logic [47:0] d);
        logic [31:0] c;
        c = ch;
        dv_in = 1'b1; chan_in = c[4:0]; data_in = d;
        tick();
        dv_in = 1'b0;
    endtask

    task automatic done_pulse();
        dac_done_in = 1'b1;
        tick();
        dac_done_in = 1'b0;
    endtask

    task automatic wait_issue();
        int k;
        k = 0;
        while (!dac_dv_out && k < 50) begin
            tick();
            k++;
        end
        if (k >= 50) chk("wait_issue_timeout", 64'd0, 64'd1);
        else tick();
    endtask

    initial begin
        rst_in = 1'b1; dv_in = 1'b0; chan_in = '0; data_in = '0;
        dac_done_in = 1'b0; clear_cnt_in = 1'b0;
        repeat (3) tick();
        @(negedge clk_in);
        chk("rst_dac_dv",   64'(dac_dv_out), 64'd0);
        chk("rst_dac_chan", 64'(dac_chan_out), 64'd0);
        chk("rst_dac_data", 64'(dac_data_out), 64'd0);
        chk("rst_dds_dv",   64'({dds_freq_dv_out, dds_phase_dv_out, dds_amp_dv_out}), 64'd0);
        chk("rst_dds_bus",  64'(dds_freq_out) | 64'(dds_phase_out) | 64'(dds_amp_out), 64'd0);
        chk("rst_counts",   64'({coalesce_cnt_out, drop_cnt_out}), 64'd0);
        tick();
        rst_in = 1'b0;
        tick();

        // First write: issue two cycles after dv_in, then hold in WAIT
        push_dac(3'd3, 16'h1234);
        send(3, 48'h1234);
        @(negedge clk_in);
        chk("lat_t1_dv_low", 64'(dac_dv_out), 64'd0);
        tick();
        @(negedge clk_in);
        chk("lat_t2_dv_high", 64'(dac_dv_out), 64'd1);
        repeat (4) tick();
        @(negedge clk_in);
        chk("wait_hold_dv",   64'(dac_dv_out), 64'd0);
        chk("wait_hold_chan", 64'(dac_chan_out), 64'd3);
        chk("wait_hold_data", 64'(dac_data_out), 64'h1234);

        // Coalescing while waiting
        send(5, 48'h0001);
        send(5, 48'h0002);
        @(negedge clk_in);
        chk("coalesce_cnt_1", 64'(coalesce_cnt_out), 64'd1);
        push_dac(3'd5, 16'h0002);
        done_pulse();
        wait_issue();
        done_pulse();

        // Round robin: rr_ptr=0 with 7,0,2 pending -> 2,7,0
        push_dac(3'd0, 16'h00AA);
        send(0, 48'h00AA);
        wait_issue();
        send(7, 48'h0077);
        send(0, 48'h0100);
        send(2, 48'h0022);
        push_dac(3'd2, 16'h0022);
        push_dac(3'd7, 16'h0077);
        push_dac(3'd0, 16'h0100);
        repeat (3) begin
            done_pulse();
            wait_issue();
        end
        done_pulse();
        @(negedge clk_in);
        chk("coalesce_after_rr", 64'(coalesce_cnt_out), 64'd1);

        // DDS paths
        push_dds(0, 4'b0010, 48'hABCDEF);
        send(8 + 1, 48'hABCDEF);
        @(negedge clk_in);
        chk("dds_freq_lat", 64'(dds_freq_dv_out), 64'b0010);
        push_dds(2, 4'b1000, 48'h3FF);
        send(16 + 3, 48'h7FF);
        push_dds(1, 4'b0100, 48'h2345);
        send(12 + 2, 48'h12345);
        tick();
        @(negedge clk_in);
        chk("dds_freq_hold", 64'(dds_freq_out), 64'hABCDEF);
        chk("dds_amp_hold",  64'(dds_amp_out), 64'h3FF);

        // Unmapped channels
        send(31, 48'h5);
        send(20, 48'h6);
        repeat (3) tick();
        @(negedge clk_in);
        chk("drop_cnt_2", 64'(drop_cnt_out), 64'd2);
        chk("drop_no_coalesce", 64'(coalesce_cnt_out), 64'd1);

        // Saturation, then clear beats a coincident drop
        dv_in = 1'b1; chan_in = 5'd31;
        repeat (65540) tick();
        dv_in = 1'b0;
        @(negedge clk_in);
        chk("drop_saturate", 64'(drop_cnt_out), 64'hFFFF);
        tick();
        clear_cnt_in = 1'b1; dv_in = 1'b1; chan_in = 5'd31;
        tick();
        clear_cnt_in = 1'b0; dv_in = 1'b0;
        @(negedge clk_in);
        chk("clear_wins_drop", 64'(drop_cnt_out), 64'd0);
        chk("clear_coalesce",  64'(coalesce_cnt_out), 64'd0);

        // Reset in WAIT with two pending
        tick();
        push_dac(3'd1, 16'h0011);
        send(1, 48'h11);
        wait_issue();
        send(4, 48'h44);
        send(6, 48'h66);
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        @(negedge clk_in);
        chk("midrst_dac_chan", 64'(dac_chan_out), 64'd0);
        chk("midrst_dac_data", 64'(dac_data_out), 64'd0);
        chk("midrst_dds_freq", 64'(dds_freq_out), 64'd0);
        chk("midrst_counts",   64'({coalesce_cnt_out, drop_cnt_out}), 64'd0);
        tick();
        done_pulse();
        repeat (10) tick();
        @(negedge clk_in);
        chk("midrst_no_issue_dv", 64'(dac_dv_out), 64'd0);
        chk("dac_sb_empty", 64'(dac_q.size()), 64'd0);
        chk("dds_sb_empty", 64'(dds_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
